// File: rtl/read_arbiter.sv
// Two-master (instruction fetch / data load) to one-slave read arbiter.
// One outstanding read at a time; the response is routed only to the granted owner.
module read_arbiter #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ir_addr_valid,
  output logic                 ir_addr_ready,
  input  logic [BUS_WIDTH-1:0] ir_addr,
  output logic                 ir_data_valid,
  input  logic                 ir_data_ready,
  output logic [BUS_WIDTH-1:0] ir_data,
  input  logic                 dr_addr_valid,
  output logic                 dr_addr_ready,
  input  logic [BUS_WIDTH-1:0] dr_addr,
  output logic                 dr_data_valid,
  input  logic                 dr_data_ready,
  output logic [BUS_WIDTH-1:0] dr_data,
  output logic                 r_addr_valid,
  input  logic                 r_addr_ready,
  output logic [BUS_WIDTH-1:0] r_addr,
  input  logic                 r_data_valid,
  output logic                 r_data_ready,
  input  logic [BUS_WIDTH-1:0] r_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  state_t               state_r;
  state_t               state_s;
  owner_t               owner_r;
  owner_t               owner_s;
  logic                 last_grant_r;
  logic                 last_grant_s;
  logic [BUS_WIDTH-1:0] addr_q_r;
  logic [BUS_WIDTH-1:0] addr_q_s;
  logic                 ir_pick_s;
  logic                 slave_ready_s;

  // State, owner, fairness pointer and captured address registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_NONE;
      last_grant_r <= GRANT_DATA;
      addr_q_r     <= '0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      addr_q_r     <= addr_q_s;
    end
  end

  // Next-state, grant and response-routing logic.
  always_comb begin
    state_s       = state_r;
    owner_s       = owner_r;
    last_grant_s  = last_grant_r;
    addr_q_s      = addr_q_r;
    ir_addr_ready = 1'b0;
    dr_addr_ready = 1'b0;
    ir_data_valid = 1'b0;
    dr_data_valid = 1'b0;
    ir_data       = '0;
    dr_data       = '0;
    r_addr_valid  = 1'b0;
    r_addr        = '0;
    r_data_ready  = 1'b0;
    slave_ready_s = 1'b0;
    // Instruction wins when alone, or on a tie when data had the last grant.
    ir_pick_s     = ir_addr_valid && (!dr_addr_valid || (last_grant_r == GRANT_DATA));

    case (state_r)
      ST_IDLE: begin
        // Grants are suppressed while reset is held so every output reads 0.
        if (rst && ir_pick_s) begin
          ir_addr_ready = 1'b1;
          owner_s       = OWN_INSTR;
          addr_q_s      = ir_addr;
          state_s       = ST_ADDR;
        end else if (rst && dr_addr_valid) begin
          dr_addr_ready = 1'b1;
          owner_s       = OWN_DATA;
          addr_q_s      = dr_addr;
          state_s       = ST_ADDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        r_addr_valid = 1'b1;
        r_addr       = addr_q_r;
        if (r_addr_ready) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        case (owner_r)
          OWN_INSTR: begin
            slave_ready_s = ir_data_ready;
            ir_data_valid = r_data_valid;
            ir_data       = r_data;
          end
          OWN_DATA: begin
            slave_ready_s = dr_data_ready;
            dr_data_valid = r_data_valid;
            dr_data       = r_data;
          end
          default: begin
            slave_ready_s = 1'b0;
          end
        endcase
        r_data_ready = slave_ready_s;
        if (r_data_valid && slave_ready_s) begin
          last_grant_s = (owner_r == OWN_DATA) ? GRANT_DATA : GRANT_INSTR;
          owner_s      = OWN_NONE;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_DATA;
        end
      end
      default: begin
        state_s = ST_IDLE;
        owner_s = OWN_NONE;
      end
    endcase
  end

endmodule
